ibex_rvfi_trace_buffer: RTL and testbench

- Downstream consumer of the core's RVFI retirement port; sits beside the simulation tracer and serves as a hardware trace sink.
- Captures one record per retired instruction into a circular FIFO and drains it as a 32-bit valid/ready word stream to an off-core trace port.
- Counts records dropped on overflow and flags the loss in the next captured record.

---
 rtl/ibex_rvfi_trace_buffer.sv | 210 +++++++++++++++++++++
 tb/tb_ibex_rvfi_trace_buffer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_rvfi_trace_buffer.sv
// rtl/ibex_rvfi_trace_buffer.sv - RVFI retirement trace FIFO drained as a 32-bit word stream; IBEX_TRACE_BUF_MEM_EN adds memory beats
module ibex_rvfi_trace_buffer #(
  parameter int unsigned Depth        = 8,
  parameter int unsigned DropCntWidth = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       trace_en_i,
  input  logic                       rvfi_valid,
  input  logic [63:0]                rvfi_order,
  input  logic [31:0]                rvfi_insn,
  input  logic                       rvfi_trap,
  input  logic                       rvfi_halt,
  input  logic                       rvfi_intr,
  input  logic [1:0]                 rvfi_mode,
  input  logic [4:0]                 rvfi_rd_addr,
  input  logic [31:0]                rvfi_rd_wdata,
  input  logic [31:0]                rvfi_pc_rdata,
  input  logic [31:0]                rvfi_mem_addr,
  input  logic [3:0]                 rvfi_mem_rmask,
  input  logic [3:0]                 rvfi_mem_wmask,
  output logic                       trace_valid_o,
  input  logic                       trace_ready_i,
  output logic [31:0]                trace_data_o,
  output logic                       trace_last_o,
  output logic [$clog2(Depth):0]     level_o,
  output logic [DropCntWidth-1:0]    drop_cnt_o,
  input  logic                       drop_clr_i
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

`ifdef IBEX_TRACE_BUF_MEM_EN
  localparam logic [2:0] LastBeat = 3'd5;
  localparam logic       ExtFmt   = 1'b1;
`else
  localparam logic [2:0] LastBeat = 3'd3;
  localparam logic       ExtFmt   = 1'b0;
`endif

  typedef enum logic {IDLE, SEND} state_e;

  // Compact header: {trap, intr, halt, mode[1:0], lost, rd_addr[4:0], order[7:0]}
  logic [18:0] hdr_mem   [Depth];
  logic [31:0] pc_mem    [Depth];
  logic [31:0] insn_mem  [Depth];
  logic [31:0] wdata_mem [Depth];
`ifdef IBEX_TRACE_BUF_MEM_EN
  logic [31:0] maddr_mem [Depth];
  logic [7:0]  mask_mem  [Depth];
`endif

  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic            lost_q;
  state_e          state_q;
  logic [2:0]      beat_q;

  logic            full, push_req, push_acc, drop, handshake, last_beat, pop;
  logic [18:0]     in_hdr;
  logic [PtrW-1:0] sel_ptr;
  logic [2:0]      sel_beat;
  logic            sel_bypass;
  logic [18:0]     sel_hdr;
  logic [31:0]     sel_pc, sel_insn, sel_wdata;
`ifdef IBEX_TRACE_BUF_MEM_EN
  logic [31:0]     sel_maddr;
  logic [7:0]      sel_mask;
`endif
  logic [31:0]     next_word;
  logic            unused_inputs;

`ifdef IBEX_TRACE_BUF_MEM_EN
  assign unused_inputs = ^rvfi_order[63:8];
`else
  assign unused_inputs = ^{rvfi_order[63:8], rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask};
`endif

  assign full      = (level_o == LvlW'(Depth));
  assign handshake = trace_valid_o && trace_ready_i;
  assign last_beat = (beat_q == LastBeat);
  assign pop       = (state_q == SEND) && handshake && last_beat;
  assign push_req  = rvfi_valid && trace_en_i;
  // A full FIFO still accepts when the head record leaves in the same cycle.
  assign push_acc  = push_req && (!full || pop);
  assign drop      = push_req && !push_acc;
  assign in_hdr    = {rvfi_trap, rvfi_intr, rvfi_halt, rvfi_mode, lost_q, rvfi_rd_addr, rvfi_order[7:0]};

  // Choose which record and beat feed the output register at the next edge.
  always_comb begin
    sel_ptr    = rd_ptr;
    sel_beat   = 3'd0;
    sel_bypass = 1'b0;
    if (state_q == SEND) begin
      if (last_beat) begin
        // Next record follows the head; if it is being written this very cycle, take it from the inputs.
        sel_ptr    = rd_ptr + PtrW'(1);
        sel_bypass = (level_o == LvlW'(1));
      end else begin
        sel_beat = beat_q + 3'd1;
      end
    end
  end

  // Fetch the selected record fields, bypassing storage for a same-cycle write.
  always_comb begin
    sel_hdr   = sel_bypass ? in_hdr        : hdr_mem[sel_ptr];
    sel_pc    = sel_bypass ? rvfi_pc_rdata : pc_mem[sel_ptr];
    sel_insn  = sel_bypass ? rvfi_insn     : insn_mem[sel_ptr];
    sel_wdata = sel_bypass ? rvfi_rd_wdata : wdata_mem[sel_ptr];
`ifdef IBEX_TRACE_BUF_MEM_EN
    sel_maddr = sel_bypass ? rvfi_mem_addr : maddr_mem[sel_ptr];
    sel_mask  = sel_bypass ? {rvfi_mem_rmask, rvfi_mem_wmask} : mask_mem[sel_ptr];
`endif
  end

  // Format the selected beat as an output word.
  always_comb begin
    next_word = 32'h0;
    case (sel_beat)
      3'd0:    next_word = {8'hA5, sel_hdr[18:13], ExtFmt, 4'h0, sel_hdr[12:0]};
      3'd1:    next_word = sel_pc;
      3'd2:    next_word = sel_insn;
      3'd3:    next_word = sel_wdata;
`ifdef IBEX_TRACE_BUF_MEM_EN
      3'd4:    next_word = sel_maddr;
      3'd5:    next_word = {sel_mask, 24'h0};
`endif
      default: next_word = 32'h0;
    endcase
  end

  // Record storage write.
  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      hdr_mem[wr_ptr]   <= in_hdr;
      pc_mem[wr_ptr]    <= rvfi_pc_rdata;
      insn_mem[wr_ptr]  <= rvfi_insn;
      wdata_mem[wr_ptr] <= rvfi_rd_wdata;
`ifdef IBEX_TRACE_BUF_MEM_EN
      maddr_mem[wr_ptr] <= rvfi_mem_addr;
      mask_mem[wr_ptr]  <= {rvfi_mem_rmask, rvfi_mem_wmask};
`endif
    end
  end

  // Pointers, occupancy, lost flag and saturating drop counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_o    <= '0;
      lost_q     <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)      rd_ptr <= rd_ptr + PtrW'(1);
      if (push_acc && !pop)      level_o <= level_o + LvlW'(1);
      else if (!push_acc && pop) level_o <= level_o - LvlW'(1);
      if (drop)          lost_q <= 1'b1;
      else if (push_acc) lost_q <= 1'b0;
      if (drop_clr_i)                  drop_cnt_o <= drop ? DropCntWidth'(1) : '0;
      else if (drop && !(&drop_cnt_o)) drop_cnt_o <= drop_cnt_o + DropCntWidth'(1);
    end
  end

  // Output FSM with registered valid/data/last; data and last only move on a handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      beat_q        <= 3'd0;
      trace_valid_o <= 1'b0;
      trace_data_o  <= 32'h0;
      trace_last_o  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (level_o != '0) begin
            state_q       <= SEND;
            beat_q        <= 3'd0;
            trace_valid_o <= 1'b1;
            trace_data_o  <= next_word;
            trace_last_o  <= 1'b0;
          end
        end
        SEND: begin
          if (handshake) begin
            if (last_beat) begin
              beat_q       <= 3'd0;
              trace_last_o <= 1'b0;
              if (level_o > LvlW'(1) || push_acc) begin
                trace_data_o <= next_word;
              end else begin
                state_q       <= IDLE;
                trace_valid_o <= 1'b0;
                trace_data_o  <= 32'h0;
              end
            end else begin
              beat_q       <= beat_q + 3'd1;
              trace_data_o <= next_word;
              trace_last_o <= ((beat_q + 3'd1) == LastBeat);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
// tb/tb_ibex_rvfi_trace_buffer.sv - randomized bench with queue-based record model for ibex_rvfi_trace_buffer
module tb_ibex_rvfi_trace_buffer;

  localparam int Depth = 8;
  localparam int DW    = 4;
  localparam int LW    = $clog2(Depth) + 1;
`ifdef IBEX_TRACE_BUF_MEM_EN
  localparam int NB  = 6;
  localparam bit EXT = 1'b1;
`else
  localparam int NB  = 4;
  localparam bit EXT = 1'b0;
`endif
  localparam int DropMax = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          trace_en = 1'b0;
  logic          rvfi_valid = 1'b0;
  logic [63:0]   rvfi_order = '0;
  logic [31:0]   rvfi_insn = '0;
  logic          rvfi_trap = 1'b0;
  logic          rvfi_halt = 1'b0;
  logic          rvfi_intr = 1'b0;
  logic [1:0]    rvfi_mode = '0;
  logic [4:0]    rvfi_rd_addr = '0;
  logic [31:0]   rvfi_rd_wdata = '0;
  logic [31:0]   rvfi_pc_rdata = '0;
  logic [31:0]   rvfi_mem_addr = '0;
  logic [3:0]    rvfi_mem_rmask = '0;
  logic [3:0]    rvfi_mem_wmask = '0;
  logic          trace_valid_o;
  logic          trace_ready = 1'b0;
  logic [31:0]   trace_data_o;
  logic          trace_last_o;
  logic [LW-1:0] level_o;
  logic [DW-1:0] drop_cnt_o;
  logic          drop_clr = 1'b0;

  ibex_rvfi_trace_buffer #(.Depth(Depth), .DropCntWidth(DW)) dut (
    .clk_i(clk), .rst_i(rst), .trace_en_i(trace_en),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
    .rvfi_mode(rvfi_mode), .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_mem_addr(rvfi_mem_addr),
    .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready),
    .trace_data_o(trace_data_o), .trace_last_o(trace_last_o),
    .level_o(level_o), .drop_cnt_o(drop_cnt_o), .drop_clr_i(drop_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: queue of whole records (word i at bits [32*i +: 32]).
  logic [191:0] q[$];
  logic [31:0]  log_q[$];
  int           beat_m = 0;
  bit           lost_m = 1'b0;
  int           drop_m = 0;
  bit           stall = 1'b0;
  logic [31:0]  prev_data = '0;
  logic         prev_last = 1'b0;

  function automatic logic [191:0] make_rec();
    logic [31:0] h;
    h = {8'hA5, rvfi_trap, rvfi_intr, rvfi_halt, rvfi_mode, lost_m, EXT, 4'h0,
         rvfi_rd_addr, rvfi_order[7:0]};
    return {rvfi_mem_rmask, rvfi_mem_wmask, 24'h0, rvfi_mem_addr, rvfi_rd_wdata,
            rvfi_insn, rvfi_pc_rdata, h};
  endfunction

  // Mid-cycle: compare outputs with the model, then apply what the coming edge does.
  always @(negedge clk) begin
    int  sz;
    bit  popm, req, acc;
    logic [191:0] head;
    if (rst) begin
      q.delete();
      beat_m = 0;
      lost_m = 1'b0;
      drop_m = 0;
      stall  = 1'b0;
    end else begin
      sz = q.size();
      check_eq("level", 64'(level_o), 64'(sz));
      check_eq("drop_cnt", 64'(drop_cnt_o), 64'(drop_m));
      if (sz == 0) check_eq("idle_valid", 64'(trace_valid_o), 64'd0);
      if (stall) begin
        check_eq("hold_valid", 64'(trace_valid_o), 64'd1);
        check_eq("hold_data", 64'(trace_data_o), 64'(prev_data));
        check_eq("hold_last", 64'(trace_last_o), 64'(prev_last));
      end
      popm = 1'b0;
      if (trace_valid_o && trace_ready) begin
        log_q.push_back(trace_data_o);
        check_eq("beat_has_record", 64'(sz != 0), 64'd1);
        if (sz != 0) begin
          head = q[0];
          check_eq($sformatf("data_beat%0d", beat_m), 64'(trace_data_o), 64'(head[32*beat_m +: 32]));
          check_eq($sformatf("last_beat%0d", beat_m), 64'(trace_last_o), 64'(beat_m == NB - 1));
        end
        beat_m++;
        if (beat_m == NB) begin
          beat_m = 0;
          popm   = 1'b1;
          if (q.size() != 0) void'(q.pop_front());
        end
      end
      req = rvfi_valid && trace_en;
      acc = req && (sz < Depth || popm);
      if (acc) begin
        q.push_back(make_rec());
        lost_m = 1'b0;
      end
      if (req && !acc) lost_m = 1'b1;
      if (drop_clr) drop_m = (req && !acc) ? 1 : 0;
      else if (req && !acc && drop_m < DropMax) drop_m++;
      stall     = trace_valid_o && !trace_ready;
      prev_data = trace_data_o;
      prev_last = trace_last_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire_rand();
    rvfi_valid     = 1'b1;
    rvfi_order     = {32'($urandom()), 32'($urandom())};
    rvfi_insn      = 32'($urandom());
    rvfi_trap      = 1'($urandom_range(0, 1));
    rvfi_halt      = 1'($urandom_range(0, 1));
    rvfi_intr      = 1'($urandom_range(0, 1));
    rvfi_mode      = 2'($urandom_range(0, 3));
    rvfi_rd_addr   = 5'($urandom_range(0, 31));
    rvfi_rd_wdata  = 32'($urandom());
    rvfi_pc_rdata  = 32'($urandom());
    rvfi_mem_addr  = 32'($urandom());
    rvfi_mem_rmask = 4'($urandom_range(0, 15));
    rvfi_mem_wmask = 4'($urandom_range(0, 15));
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    rst = 1'b0;
    rvfi_valid = 1'b0;
    drop_clr = 1'b0;
    trace_ready = 1'b1;
    while ((q.size() != 0 || trace_valid_o) && n < budget) begin
      tick();
      n++;
    end
    check_eq("drain_in_budget", 64'(n < budget), 64'd1);
    tick();
  endtask

  initial begin
    int n;
    // Reset values
    tick();
    tick();
    check_eq("rst_valid", 64'(trace_valid_o), 64'd0);
    check_eq("rst_last", 64'(trace_last_o), 64'd0);
    check_eq("rst_data", 64'(trace_data_o), 64'd0);
    check_eq("rst_level", 64'(level_o), 64'd0);
    check_eq("rst_drop", 64'(drop_cnt_o), 64'd0);

    // Single directed retire
    rst = 1'b0;
    trace_en = 1'b1;
    trace_ready = 1'b1;
    log_q.delete();
    rvfi_valid = 1'b1;
    rvfi_pc_rdata = 32'h0000_0080;
    rvfi_insn = 32'h0050_0093;
    rvfi_rd_addr = 5'd1;
    rvfi_rd_wdata = 32'd5;
    rvfi_order = 64'd3;
    tick();
    rvfi_valid = 1'b0;
    drain(50);
    check_eq("single_nbeats", 64'(log_q.size()), 64'(NB));
    if (log_q.size() >= 4) begin
      check_eq("single_hdr", 64'(log_q[0]), 64'(32'hA500_0103 | (32'(EXT) << 17)));
      check_eq("single_pc", 64'(log_q[1]), 64'h80);
      check_eq("single_insn", 64'(log_q[2]), 64'h0050_0093);
      check_eq("single_wdata", 64'(log_q[3]), 64'h5);
    end
    check_eq("single_level", 64'(level_o), 64'd0);

    // Backpressure mid-record
    retire_rand();
    tick();
    rvfi_valid = 1'b0;
    tick();
    tick();
    trace_ready = 1'b0;
    repeat (5) tick();
    drain(50);

    // Overflow: 10 retires into a stalled FIFO
    trace_ready = 1'b0;
    log_q.delete();
    repeat (10) begin
      retire_rand();
      tick();
    end
    rvfi_valid = 1'b0;
    check_eq("ovf_level", 64'(level_o), 64'(Depth));
    check_eq("ovf_drop", 64'(drop_cnt_o), 64'd2);
    trace_ready = 1'b1;
    repeat (3 * NB) tick();
    retire_rand();
    tick();
    drain(300);
    check_eq("ovf_nbeats", 64'(log_q.size()), 64'(9 * NB));
    if (log_q.size() >= 9 * NB) begin
      for (int i = 0; i < 9; i++) begin
        logic [31:0] w;
        w = log_q[i * NB];
        check_eq($sformatf("ovf_lost_rec%0d", i), 64'(w[18]), 64'(i == 8));
      end
    end

    // Full FIFO: retire exactly on the last-beat pop
    trace_ready = 1'b0;
    repeat (Depth) begin
      retire_rand();
      tick();
    end
    rvfi_valid = 1'b0;
    trace_ready = 1'b1;
    n = 0;
    while (!(trace_valid_o && trace_last_o) && n < 20) begin
      tick();
      n++;
    end
    check_eq("fullpop_reached_last", 64'(n < 20), 64'd1);
    retire_rand();
    tick();
    rvfi_valid = 1'b0;
    trace_ready = 1'b0;
    check_eq("fullpop_level", 64'(level_o), 64'(Depth));
    check_eq("fullpop_drop", 64'(drop_cnt_o), 64'd2);

    // Drop counter saturation and clear
    repeat (20) begin
      retire_rand();
      tick();
    end
    check_eq("drop_sat", 64'(drop_cnt_o), 64'(DropMax));
    retire_rand();
    drop_clr = 1'b1;
    tick();
    check_eq("drop_clr_and_drop", 64'(drop_cnt_o), 64'd1);
    rvfi_valid = 1'b0;
    tick();
    check_eq("drop_clr", 64'(drop_cnt_o), 64'd0);
    drop_clr = 1'b0;
    drain(300);

    // Reset during beat2
    retire_rand();
    tick();
    rvfi_valid = 1'b0;
    n = 0;
    while (!(trace_valid_o && beat_m == 2) && n < 20) begin
      tick();
      n++;
    end
    check_eq("rst_mid_reached_beat2", 64'(n < 20), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst_mid_valid", 64'(trace_valid_o), 64'd0);
    check_eq("rst_mid_level", 64'(level_o), 64'd0);
    check_eq("rst_mid_drop", 64'(drop_cnt_o), 64'd0);
    log_q.delete();
    retire_rand();
    tick();
    drain(50);
    check_eq("rst_mid_clean_nbeats", 64'(log_q.size()), 64'(NB));

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 2) != 0) retire_rand();
      else rvfi_valid = 1'b0;
      trace_en    = ($urandom_range(0, 7) != 0);
      trace_ready = 1'($urandom_range(0, 1));
      drop_clr    = ($urandom_range(0, 15) == 0);
      rst         = ($urandom_range(0, 199) == 0);
      tick();
    end
    trace_en = 1'b1;
    drain(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
